axi4_burst_selftest_master: RTL

Synthesizable AXI4 full master that writes NUM_BURSTS incrementing bursts of a known data pattern to a memory-mapped slave, reads them back and checks every beat and response. It generalises the single 8-beat write/read/compare sequence of our IP bring-up bench to run in hardware next to the lane-detection IP. It reports pass/fail and error statistics to a status register or ILA.

---
 rtl/axi4_selftest_pkg.sv | 41 ++++
 rtl/axi4_selftest_checker.sv | 89 ++++++++
 rtl/axi4_burst_selftest_master.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_selftest_pkg.sv
// ---------------------------------------------------------------------------
// axi4_selftest_pkg
// Shared types and helpers for the AXI4 burst self-test master.
//   state_e        : sequencing FSM states (exposed on dbg_state of the top)
//   AXI_BURST_INCR : AxBURST encoding for incrementing bursts
//   AXI_RESP_OKAY  : xRESP encoding for a good response
//   beat_addr()    : byte address of burst b
//   pattern()      : data word written for global beat k (seed + k + 1)
// ---------------------------------------------------------------------------
package axi4_selftest_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_RESP = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_DATA = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // Widest supported data bus; callers truncate to their own DATA_W.
    localparam int unsigned PAT_W = 128;

    function automatic logic [63:0] beat_addr(input logic [63:0] base,
                                              input logic [31:0] b,
                                              input logic [31:0] burst_len,
                                              input logic [31:0] bytes_per_beat);
        return base + 64'(b) * 64'(burst_len) * 64'(bytes_per_beat);
    endfunction

    // Truncating the 128-bit sum gives the result modulo 2^DATA_W.
    function automatic logic [PAT_W-1:0] pattern(input logic [PAT_W-1:0] seed,
                                                 input logic [31:0]      k);
        return seed + PAT_W'(k) + PAT_W'(1);
    endfunction

endpackage

// File: rtl/axi4_selftest_checker.sv
// ---------------------------------------------------------------------------
// axi4_selftest_checker
// Read-back comparison and error statistics for the self-test master.
//   clk, rst_n      : clock, asynchronous active-low reset
//   clear           : clear statistics (accepted start)
//   r_hs            : R-channel handshake this cycle
//   r_data/resp/last: R-channel payload
//   exp_data/last   : expected data and RLAST for the current read beat
//   beat_idx        : global beat index k of the current read beat
//   b_hs, b_resp    : B-channel handshake and response
//   extra_err       : one additional error event (e.g. watchdog expiry)
//   err_cnt         : saturating error count
//   first_err_beat  : k of first data mismatch, 0xFFFF if none
// ---------------------------------------------------------------------------
module axi4_selftest_checker
    import axi4_selftest_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              r_hs,
    input  logic [DATA_W-1:0] r_data,
    input  logic [1:0]        r_resp,
    input  logic              r_last,
    input  logic [DATA_W-1:0] exp_data,
    input  logic              exp_last,
    input  logic [15:0]       beat_idx,
    input  logic              b_hs,
    input  logic [1:0]        b_resp,
    input  logic              extra_err,
    output logic [15:0]       err_cnt,
    output logic [15:0]       first_err_beat
);

    logic [15:0] err_cnt_q, err_cnt_d;
    logic [15:0] first_err_beat_q, first_err_beat_d;
    logic        first_seen_q, first_seen_d;

    logic data_bad;
    logic beat_bad;
    logic b_bad;
    logic err_event;

    assign data_bad = r_hs && (r_data != exp_data);
    // Data, response and RLAST faults on one beat collapse into one event.
    assign beat_bad = data_bad ||
                      (r_hs && ((r_resp != AXI_RESP_OKAY) || (r_last != exp_last)));
    assign b_bad     = b_hs && (b_resp != AXI_RESP_OKAY);
    assign err_event = beat_bad || b_bad || extra_err;

    always_comb begin
        err_cnt_d        = err_cnt_q;
        first_err_beat_d = first_err_beat_q;
        first_seen_d     = first_seen_q;
        if (clear) begin
            err_cnt_d        = '0;
            first_err_beat_d = 16'hFFFF;
            first_seen_d     = 1'b0;
        end else begin
            if (err_event && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
            // A separate flag keeps a genuine mismatch at k=0xFFFF from
            // looking like "none recorded yet".
            if (data_bad && !first_seen_q) begin
                first_err_beat_d = beat_idx;
                first_seen_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q        <= '0;
            first_err_beat_q <= 16'hFFFF;
            first_seen_q     <= 1'b0;
        end else begin
            err_cnt_q        <= err_cnt_d;
            first_err_beat_q <= first_err_beat_d;
            first_seen_q     <= first_seen_d;
        end
    end

    assign err_cnt        = err_cnt_q;
    assign first_err_beat = first_err_beat_q;

endmodule

// File: rtl/axi4_burst_selftest_master.sv
// ---------------------------------------------------------------------------
// axi4_burst_selftest_master
// AXI4 master that writes NUM_BURSTS INCR bursts of BURST_LEN beats carrying
// seed+k+1 (k = global beat index), reads them back and checks every beat
// and every write response.
//   ACLK, ARESETN   : clock, asynchronous active-low reset
//   start, seed     : run request (accepted in IDLE/DONE) and pattern offset
//   busy, done, pass: run status; pass = done && err_cnt == 0
//   err_cnt         : saturating failed beat/response count
//   first_err_beat  : k of first read data mismatch, 0xFFFF if none
//   timeout         : watchdog expired (AXI4_SELFTEST_TIMEOUT_EN builds only)
//   M_AXI_*         : AXI4 AW/W/B/AR/R channels (IDs driven 0)
//   dbg_state       : current FSM state
// Optional feature macro: AXI4_SELFTEST_TIMEOUT_EN adds parameter
// TIMEOUT_CYC and the timeout output.
//
// Handshake rule on every channel: a transfer happens on a rising ACLK edge
// where VALID && READY. This master raises VALID from the state register
// only, keeps it and the payload constant until that edge, and raises READY
// only in the state that consumes the channel.
// ---------------------------------------------------------------------------
module axi4_burst_selftest_master
    import axi4_selftest_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ID_W       = 1,
    parameter int unsigned       BURST_LEN  = 8,
    parameter int unsigned       NUM_BURSTS = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
`ifdef AXI4_SELFTEST_TIMEOUT_EN
    ,
    parameter int unsigned       TIMEOUT_CYC = 4096
`endif
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                start,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_cnt,
    output logic [15:0]         first_err_beat,
`ifdef AXI4_SELFTEST_TIMEOUT_EN
    output logic                timeout,
`endif
    output logic [ID_W-1:0]     M_AXI_AWID,
    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic [7:0]          M_AXI_AWLEN,
    output logic [2:0]          M_AXI_AWSIZE,
    output logic [1:0]          M_AXI_AWBURST,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WLAST,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [ID_W-1:0]     M_AXI_BID,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,
    output logic [ID_W-1:0]     M_AXI_ARID,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic [7:0]          M_AXI_ARLEN,
    output logic [2:0]          M_AXI_ARSIZE,
    output logic [1:0]          M_AXI_ARBURST,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    input  logic [ID_W-1:0]     M_AXI_RID,
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RLAST,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY,
    output logic [2:0]          dbg_state
);

    localparam int unsigned       BYTES      = DATA_W / 8;
    localparam int unsigned       BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned       BURST_W    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0] LAST_BURST = BURST_W'(NUM_BURSTS - 1);

    state_e               state_q, state_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [BEAT_W-1:0]    beat_q,  beat_d;
    logic [31:0]          gbeat_q, gbeat_d;   // global beat k, restarts for reads
    logic [DATA_W-1:0]    seed_q,  seed_d;
    logic                 done_q,  done_d;

    logic                 start_acc;
    logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                 timeout_evt;
    logic [ADDR_W-1:0]    burst_addr;
    logic [DATA_W-1:0]    cur_pattern;
    logic                 cur_last;

    logic                 unused_ids;
    assign unused_ids = ^{M_AXI_BID, M_AXI_RID};

    assign start_acc = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign aw_hs = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs  = M_AXI_WVALID  && M_AXI_WREADY;
    assign b_hs  = M_AXI_BVALID  && M_AXI_BREADY;
    assign ar_hs = M_AXI_ARVALID && M_AXI_ARREADY;
    assign r_hs  = M_AXI_RVALID  && M_AXI_RREADY;

    assign burst_addr  = ADDR_W'(beat_addr(64'(BASE_ADDR), 32'(burst_q), BURST_LEN, BYTES));
    assign cur_pattern = DATA_W'(pattern(PAT_W'(seed_q), gbeat_q));
    assign cur_last    = (beat_q == LAST_BEAT);

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        beat_d  = beat_q;
        gbeat_d = gbeat_q;
        seed_d  = seed_q;
        done_d  = done_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc) begin
                    state_d = ST_WR_ADDR;
                    seed_d  = seed;
                    burst_d = '0;
                    beat_d  = '0;
                    gbeat_d = '0;
                    done_d  = 1'b0;
                end
            end
            ST_WR_ADDR: begin
                if (aw_hs) state_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                if (w_hs) begin
                    gbeat_d = gbeat_q + 32'd1;
                    if (cur_last) begin
                        beat_d  = '0;
                        state_d = ST_WR_RESP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    if (burst_q == LAST_BURST) begin
                        burst_d = '0;
                        gbeat_d = '0;
                        state_d = ST_RD_ADDR;
                    end else begin
                        burst_d = burst_q + 1'b1;
                        state_d = ST_WR_ADDR;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (ar_hs) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (r_hs) begin
                    gbeat_d = gbeat_q + 32'd1;
                    if (cur_last) begin
                        beat_d = '0;
                        if (burst_q == LAST_BURST) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            burst_d = burst_q + 1'b1;
                            state_d = ST_RD_ADDR;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Watchdog expiry abandons the run; leaving the busy states drops
        // every VALID/READY on the next edge.
        if (timeout_evt) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            burst_q <= '0;
            beat_q  <= '0;
            gbeat_q <= '0;
            seed_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            beat_q  <= beat_d;
            gbeat_q <= gbeat_d;
            seed_q  <= seed_d;
            done_q  <= done_d;
        end
    end

    // ----------------------------------------------------------- watchdog
`ifdef AXI4_SELFTEST_TIMEOUT_EN
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        timeout_q, timeout_d;
    logic        any_hs;

    assign any_hs      = aw_hs || w_hs || b_hs || ar_hs || r_hs;
    assign timeout_evt = busy && !any_hs && (to_cnt_q == 32'(TIMEOUT_CYC - 1));

    always_comb begin
        to_cnt_d  = (busy && !any_hs) ? (to_cnt_q + 32'd1) : '0;
        timeout_d = timeout_q;
        if (start_acc) begin
            timeout_d = 1'b0;
        end else if (timeout_evt) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout_evt = 1'b0;
`endif

    // ------------------------------------------------------------ checker
    axi4_selftest_checker #(
        .DATA_W (DATA_W)
    ) u_checker (
        .clk            (ACLK),
        .rst_n          (ARESETN),
        .clear          (start_acc),
        .r_hs           (r_hs),
        .r_data         (M_AXI_RDATA),
        .r_resp         (M_AXI_RRESP),
        .r_last         (M_AXI_RLAST),
        .exp_data       (cur_pattern),
        .exp_last       (cur_last),
        .beat_idx       (gbeat_q[15:0]),
        .b_hs           (b_hs),
        .b_resp         (M_AXI_BRESP),
        .extra_err      (timeout_evt),
        .err_cnt        (err_cnt),
        .first_err_beat (first_err_beat)
    );

    // ------------------------------------------------------------ outputs
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = done_q;
    assign pass      = done_q && (err_cnt == 16'd0);
    assign dbg_state = state_q;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = burst_addr;
    assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_AWSIZE  = 3'($clog2(BYTES));
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_AWVALID = (state_q == ST_WR_ADDR);

    assign M_AXI_WDATA   = cur_pattern;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = cur_last;
    assign M_AXI_WVALID  = (state_q == ST_WR_DATA);

    assign M_AXI_BREADY  = (state_q == ST_WR_RESP);

    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = burst_addr;
    assign M_AXI_ARLEN   = 8'(BURST_LEN - 1);
    assign M_AXI_ARSIZE  = 3'($clog2(BYTES));
    assign M_AXI_ARBURST = AXI_BURST_INCR;
    assign M_AXI_ARVALID = (state_q == ST_RD_ADDR);

    assign M_AXI_RREADY  = (state_q == ST_RD_DATA);

endmodule
